// File: rtl/dm_store_buffer.sv
// In-order store buffer between the MEM-stage store path and data memory, with load forwarding.
// Optional build macro SB_MERGE_EN: a store to the youngest entry's word merges into that entry.
module dm_store_buffer #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned PTR_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             st_valid,
    output logic             st_ready,
    input  logic [31:0]      st_addr,
    input  logic [31:0]      st_data,
    input  logic [3:0]       st_be,
    input  logic [31:0]      st_pc,
    input  logic             ld_valid,
    input  logic [31:0]      ld_addr,
    output logic             ld_hit,
    output logic [31:0]      ld_data,
    output logic             ld_stall,
    input  logic             drain_en,
    output logic             dm_we,
    output logic [31:0]      dm_addr,
    output logic [31:0]      dm_wd,
    output logic [3:0]       dm_be,
    output logic [31:0]      dm_pc,
    output logic             empty,
    output logic [PTR_W:0]   count
);

    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned AW    = 30;

    logic [AW-1:0]    addr_q [DEPTH];
    logic [31:0]      data_q [DEPTH];
    logic [3:0]       be_q   [DEPTH];
    logic [31:0]      pc_q   [DEPTH];
    logic [DEPTH-1:0] valid_q;
    logic [PTR_W-1:0] head_q, tail_q;
    logic [CNT_W-1:0] count_q, count_d;

    logic             full_c, merge_ok_c, merge_c, alloc_c, pop_c;
    logic             lk_hit_c;
    logic [3:0]       lk_be_c;
    logic [31:0]      lk_data_c;
    logic [PTR_W-1:0] lk_idx_c;
    logic             unused_addr_lsb_c;

    assign unused_addr_lsb_c = ^{st_addr[1:0], ld_addr[1:0]};

    assign empty  = (count_q == '0);
    assign count  = count_q;
    assign full_c = (count_q == CNT_W'(DEPTH));
    assign pop_c  = !empty && drain_en;
    assign dm_we  = pop_c;

`ifdef SB_MERGE_EN
    logic [PTR_W-1:0] yng_idx_c;
    logic [31:0]      st_mask_c;

    assign yng_idx_c  = tail_q - PTR_W'(1);
    assign st_mask_c  = {{8{st_be[3]}}, {8{st_be[2]}}, {8{st_be[1]}}, {8{st_be[0]}}};
    // A lone entry that is leaving this cycle cannot absorb the store.
    assign merge_ok_c = !empty && valid_q[yng_idx_c] && (addr_q[yng_idx_c] == st_addr[31:2])
                        && !((count_q == CNT_W'(1)) && pop_c);
`else
    assign merge_ok_c = 1'b0;
`endif

    assign st_ready = !full_c || merge_ok_c;
    assign merge_c  = st_valid && merge_ok_c;
    assign alloc_c  = st_valid && !full_c && !merge_ok_c;
    assign count_d  = count_q + CNT_W'(alloc_c) - CNT_W'(pop_c);

    // Head entry is presented to the DM port whenever the buffer holds anything.
    assign dm_addr = empty ? 32'h0 : {addr_q[head_q], 2'b00};
    assign dm_wd   = empty ? 32'h0 : data_q[head_q];
    assign dm_be   = empty ? 4'h0  : be_q[head_q];
    assign dm_pc   = empty ? 32'h0 : pc_q[head_q];

    // Walk oldest to youngest so the last match seen is the youngest.
    always_comb begin
        lk_hit_c  = 1'b0;
        lk_be_c   = 4'h0;
        lk_data_c = 32'h0;
        lk_idx_c  = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            lk_idx_c = head_q + PTR_W'(i);
            if ((CNT_W'(i) < count_q) && valid_q[lk_idx_c] &&
                (addr_q[lk_idx_c] == ld_addr[31:2])) begin
                lk_hit_c  = 1'b1;
                lk_be_c   = be_q[lk_idx_c];
                lk_data_c = data_q[lk_idx_c];
            end
        end
    end

    assign ld_hit   = ld_valid && lk_hit_c && (lk_be_c == 4'hF);
    assign ld_stall = ld_valid && lk_hit_c && (lk_be_c != 4'hF);
    assign ld_data  = ld_hit ? lk_data_c : 32'h0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            valid_q <= '0;
        end else begin
            if (pop_c) begin
                head_q          <= head_q + PTR_W'(1);
                valid_q[head_q] <= 1'b0;
            end
            if (alloc_c) begin
                tail_q          <= tail_q + PTR_W'(1);
                valid_q[tail_q] <= 1'b1;
            end
            count_q <= count_d;
        end
    end

    // Payload storage carries no reset; validity is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (alloc_c) begin
            addr_q[tail_q] <= st_addr[31:2];
            data_q[tail_q] <= st_data;
            be_q[tail_q]   <= st_be;
            pc_q[tail_q]   <= st_pc;
        end
`ifdef SB_MERGE_EN
        else if (merge_c) begin
            data_q[yng_idx_c] <= (data_q[yng_idx_c] & ~st_mask_c) | (st_data & st_mask_c);
            be_q[yng_idx_c]   <= be_q[yng_idx_c] | st_be;
            pc_q[yng_idx_c]   <= st_pc;
        end
`endif
    end

endmodule
